mole_ctrl: RTL
==============

# mole_ctrl

Game-round controller for the whack-a-mole design, directly downstream of the 5-bit pseudo-random source. It samples the random value to choose which hole lights, holds the mole up for a fixed window, and detects a correct button press (hit) or window expiry (miss). It keeps the score and round count, and signals the end of a game after a fixed number of rounds. Outputs drive the LED/display stage; `btn` comes from the debounced button stage.

## Interface
Parameters:
- `N_HOLES`, 16: number of holes; must be a power of two, at most 32; `HOLE_W = log2(N_HOLES)`.
- `UP_CYCLES`, 8: cycles the mole stays up.
- `GAP_CYCLES`, 4: cycles with no mole between rounds.
- `ROUNDS`, 20: moles per game.
- `SCORE_W`, 8: score width.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `rand`  in  5  random value from the upstream generator; sampled only at mole launch.
- `start`  in  1  level or pulse; begins a game when idle.
- `btn`  in  N_HOLES  debounced button levels, one per hole.
- `mole`  out  N_HOLES  one-hot lit hole; 0 when no mole is up.
- `score`  out  SCORE_W  hits this game.
- `round_cnt`  out  8  moles launched this game.
- `busy`  out  1  game in progress.
- `hit`, `miss`  out  1  one-cycle event pulses.
- `done`  out  1  one-cycle pulse at game end.

## Operation
- Reset values: state IDLE; `mole`, `score`, `round_cnt`, `busy`, `hit`, `miss` and `done` all 0; button history 0.
- Button presses are rising edges: `press = btn & ~btn_q`, where `btn_q` is `btn` registered. A button held down generates one press only.
- States:
  - IDLE: `start=1` clears `score` and `round_cnt`, sets `busy`, and moves to GAP.
  - GAP: on timer expiry, pick a hole, load `mole`, increment `round_cnt`, and move to UP.
  - UP:
    - A press on the lit hole pulses `hit`, increments `score` (saturating at all-ones), clears `mole`, and ends the round.
    - Otherwise, on timer expiry, pulse `miss`, clear `mole`, and end the round.
  - End of round: if `round_cnt == ROUNDS`, go to DONE; otherwise go to GAP.
  - DONE: `done=1` and `busy=0` for one cycle, then IDLE. `score` holds until the next start.
- Hole choice:
  - `h = rand[HOLE_W-1:0]`.
  - If `h` equals the previous hole, use `(h+1) mod N_HOLES` instead.
  - The previous hole is 0 after reset.
- Simultaneous events:
  - A correct press and timer expiry in the same cycle count as a hit.
  - Presses on unlit holes, and any presses outside UP, are ignored.
  - A correct press together with wrong presses counts as a hit.
- `start` while `busy`: ignored.
- `rst` mid-game: the next edge returns everything to reset values; there is no `done` pulse.

## Timing
- All outputs are registered.
- Timer: loaded with `N-1` on state entry and decremented each cycle. The state exits when the timer reads 0, so GAP lasts `GAP_CYCLES` cycles and UP lasts at most `UP_CYCLES` cycles.
- `start` sampled at edge t:
  - `busy` is 1 from t+1.
  - `mole` is valid from t+1+GAP_CYCLES.
- `btn` rising and sampled at edge k during UP: `hit` is high and `mole` is 0 from k+1 (one cycle of latency).
- No press: `miss` goes high in the cycle after the last UP cycle; the next mole follows GAP_CYCLES cycles later.
- `done` rises in the cycle after the final `hit`/`miss` pulse.

## Configuration
- `MOLE_MISS_PENALTY_EN`:
  - Defined: a press on an unlit hole during UP, with no correct press in the same cycle, decrements `score`, saturating at 0. The round continues.
  - Undefined: wrong presses have no effect.

## Structure
- Package `mole_pkg` holds:
  - the state enum (IDLE, GAP, UP, DONE);
  - default timing constants;
  - the `HOLE_W` helper function.
- Sub-module `btn_edge`: N-bit registered rising-edge detector with synchronous `rst`.
- The FSM, timer, hole select and score logic live in `mole_ctrl`.

## Test plan
All scenarios use N_HOLES=16, UP_CYCLES=8, GAP_CYCLES=4, ROUNDS=3.
- Reset: hold `rst` for 2 cycles -> all outputs 0; state IDLE.
- Hit: `start` at t with `rand=5` -> `mole=16'h0020` at t+5; raise `btn[5]` -> next cycle `hit=1`, `score=1`, `mole=0`.
- Miss: let UP run with no press -> `mole` stays up for 8 cycles, then `miss=1`; `score` unchanged.
- Repeat avoidance: previous hole 5, `rand=21` -> `mole=16'h0040` (hole 6). `rand=15` after hole 15 -> hole 0.
- Game end: 3 rounds -> `done` pulses once, `busy=0`, `score` held. `start` pulsed mid-game is ignored. `rst` in UP -> all outputs 0 next cycle.
- With `MOLE_MISS_PENALTY_EN`:
  - score 1, press `btn[2]` while hole 5 lit -> `score=0`; press again -> stays 0.
  - press `btn[2]` and `btn[5]` together -> hit, `score` +1.

Source files
------------

// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mole_pkg
//  Description : Shared types, default timing constants and the hole-index
//                width helper for the whack-a-mole round controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

  // Round-controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Default game parameters
  localparam int C_N_HOLES    = 16;
  localparam int C_UP_CYCLES  = 8;
  localparam int C_GAP_CYCLES = 4;
  localparam int C_ROUNDS     = 20;
  localparam int C_SCORE_W    = 8;

  // Phase timer width; comfortably covers any practical window length
  localparam int C_TMR_W      = 16;

  // Width of the random input from the upstream generator
  localparam int C_RAND_W     = 5;

  // Number of bits needed to index n holes (n is a power of two, <= 32)
  function automatic int hole_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage : mole_pkg
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge
//  Description : N-bit rising-edge detector. Registers the button levels and
//                flags bits that are high now but were low last cycle, so a
//                held button yields a single press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] press
);

  logic [WIDTH-1:0] r_btn_q;

  // Button history, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_q <= '0;
    end else begin
      r_btn_q <= btn;
    end
  end

  assign press = btn & ~r_btn_q;

endmodule : btn_edge
`default_nettype wire

// File: rtl/mole_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mole_ctrl
//  Description : Whack-a-mole round controller. Picks a hole from the random
//                source, holds the mole up for a fixed window, scores hits,
//                flags misses and ends the game after a fixed round count.
//                Optional build macro MOLE_MISS_PENALTY_EN: a press on an
//                unlit hole during UP (with no correct press) costs a point.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_ctrl
  import mole_pkg::*;
#(
  parameter int N_HOLES    = C_N_HOLES,
  parameter int UP_CYCLES  = C_UP_CYCLES,
  parameter int GAP_CYCLES = C_GAP_CYCLES,
  parameter int ROUNDS     = C_ROUNDS,
  parameter int SCORE_W    = C_SCORE_W
) (
  input  logic                clk,
  input  logic                rst,
  // "rand" is a reserved word in SystemVerilog, hence the suffix
  input  logic [C_RAND_W-1:0] rand_val,
  input  logic                start,
  input  logic [N_HOLES-1:0]  btn,
  output logic [N_HOLES-1:0]  mole,
  output logic [SCORE_W-1:0]  score,
  output logic [7:0]          round_cnt,
  output logic                busy,
  output logic                hit,
  output logic                miss,
  output logic                done
);

  localparam int HOLE_W = hole_w(N_HOLES);

  localparam logic [C_TMR_W-1:0]  c_up_load   = C_TMR_W'(UP_CYCLES - 1);
  localparam logic [C_TMR_W-1:0]  c_gap_load  = C_TMR_W'(GAP_CYCLES - 1);
  localparam logic [C_RAND_W-1:0] c_hole_mask = C_RAND_W'(N_HOLES - 1);
  localparam logic [7:0]          c_rounds    = 8'(ROUNDS);
  localparam logic [SCORE_W-1:0]  c_score_max = '1;

  // Registered state
  state_t               r_state;
  logic [C_TMR_W-1:0]   r_timer;
  logic [N_HOLES-1:0]   r_mole;
  logic [SCORE_W-1:0]   r_score;
  logic [7:0]           r_round;
  logic                 r_busy;
  logic                 r_hit;
  logic                 r_miss;
  logic                 r_done;
  logic [C_RAND_W-1:0]  r_prev_hole;

  // Next-state values
  state_t               w_state_n;
  logic [C_TMR_W-1:0]   w_timer_n;
  logic [N_HOLES-1:0]   w_mole_n;
  logic [SCORE_W-1:0]   w_score_n;
  logic [7:0]           w_round_n;
  logic                 w_busy_n;
  logic                 w_hit_n;
  logic                 w_miss_n;
  logic                 w_done_n;
  logic [C_RAND_W-1:0]  w_prev_hole_n;
  logic                 w_end_round;

  // Press detection and hole selection
  logic [N_HOLES-1:0]   w_press;
  logic [C_RAND_W-1:0]  w_hole_raw;
  logic [C_RAND_W-1:0]  w_hole_alt;
  logic [C_RAND_W-1:0]  w_hole_sel;
  logic [N_HOLES-1:0]   w_mole_sel;
  logic                 w_hit_now;
  logic                 w_timer_zero;

  btn_edge #(
    .WIDTH (N_HOLES)
  ) u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (w_press)
  );

  // Hole index kept in the full random width and masked, so any hole count
  // up to 32 needs no separate slicing path; repeat of the previous hole
  // bumps to the next hole, wrapping at N_HOLES.
  assign w_hole_raw   = rand_val & c_hole_mask;
  assign w_hole_alt   = (w_hole_raw + C_RAND_W'(1)) & c_hole_mask;
  assign w_hole_sel   = (w_hole_raw == r_prev_hole) ? w_hole_alt : w_hole_raw;
  assign w_mole_sel   = N_HOLES'(1) << w_hole_sel;
  assign w_hit_now    = |(w_press & r_mole);
  assign w_timer_zero = (r_timer == '0);

  // State, timer, outputs and history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_mole      <= '0;
      r_score     <= '0;
      r_round     <= '0;
      r_busy      <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_done      <= 1'b0;
      r_prev_hole <= '0;
    end else begin
      r_state     <= w_state_n;
      r_timer     <= w_timer_n;
      r_mole      <= w_mole_n;
      r_score     <= w_score_n;
      r_round     <= w_round_n;
      r_busy      <= w_busy_n;
      r_hit       <= w_hit_n;
      r_miss      <= w_miss_n;
      r_done      <= w_done_n;
      r_prev_hole <= w_prev_hole_n;
    end
  end

  // Next-state, timer and scoring decisions
  always_comb begin
    w_state_n     = r_state;
    w_timer_n     = r_timer;
    w_mole_n      = r_mole;
    w_score_n     = r_score;
    w_round_n     = r_round;
    w_busy_n      = r_busy;
    w_hit_n       = 1'b0;
    w_miss_n      = 1'b0;
    w_done_n      = 1'b0;
    w_prev_hole_n = r_prev_hole;
    w_end_round   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_score_n = '0;
          w_round_n = '0;
          w_busy_n  = 1'b1;
          w_timer_n = c_gap_load;
          w_state_n = ST_GAP;
        end
      end

      ST_GAP: begin
        if (w_timer_zero) begin
          w_mole_n      = w_mole_sel;
          w_round_n     = r_round + 8'd1;
          w_prev_hole_n = w_hole_sel;
          w_timer_n     = c_up_load;
          w_state_n     = ST_UP;
        end else begin
          w_timer_n = r_timer - C_TMR_W'(1);
        end
      end

      ST_UP: begin
        if (w_hit_now) begin
          // A correct press wins over expiry and over any wrong presses
          w_hit_n     = 1'b1;
          w_mole_n    = '0;
          w_end_round = 1'b1;
          if (r_score != c_score_max) begin
            w_score_n = r_score + SCORE_W'(1);
          end
        end else begin
`ifdef MOLE_MISS_PENALTY_EN
          if (|(w_press & ~r_mole) && (r_score != '0)) begin
            w_score_n = r_score - SCORE_W'(1);
          end
`endif
          if (w_timer_zero) begin
            w_miss_n    = 1'b1;
            w_mole_n    = '0;
            w_end_round = 1'b1;
          end else begin
            w_timer_n = r_timer - C_TMR_W'(1);
          end
        end
      end

      ST_DONE: begin
        w_done_n  = 1'b1;
        w_busy_n  = 1'b0;
        w_state_n = ST_IDLE;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    // round_cnt already counts the mole just retired
    if (w_end_round) begin
      if (r_round == c_rounds) begin
        w_state_n = ST_DONE;
      end else begin
        w_timer_n = c_gap_load;
        w_state_n = ST_GAP;
      end
    end
  end

  assign mole      = r_mole;
  assign score     = r_score;
  assign round_cnt = r_round;
  assign busy      = r_busy;
  assign hit       = r_hit;
  assign miss      = r_miss;
  assign done      = r_done;

endmodule : mole_ctrl
`default_nettype wire
